// File: rtl/mac_accumulator_if.sv
// -----------------------------------------------------------------------------
// mac_accumulator_if
//   Streaming handshake bundle for mac_accumulator.
//   Input side : in_data / in_valid / in_last  -> stage,  in_ready  <- stage
//   Output side: out_data / out_count / out_sat / out_valid <- stage,
//                out_ready -> stage
//   Modports:
//     master : upstream producer + downstream consumer (drives inputs,
//              observes results)
//     slave  : the accumulator stage itself
// -----------------------------------------------------------------------------
interface mac_accumulator_if #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int COUNT_WIDTH = 16
);
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_valid;
  logic                        in_last;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [COUNT_WIDTH-1:0]      out_count;
  logic                        out_sat;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_sat, out_valid
  );
endinterface

// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//   Sums a stream of signed terms into a wide running accumulator. On the
//   group-final term (in_last) the total is arithmetically shifted right by
//   OUT_SCALE, narrowed to OUT_WIDTH and held on a valid/ready output until
//   consumed. No new terms are accepted while a result is pending.
//
// Ports
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : mac_accumulator_if.slave
//          in_data/in_valid/in_last/in_ready    term stream
//          out_data/out_count/out_sat/out_valid/out_ready  group result
//
// Configuration macro
//   ACC_SATURATE_EN : defined   -> narrowing clamps to the OUT_WIDTH range
//                                  and out_sat flags a clamped result
//                     undefined -> narrowing keeps the low OUT_WIDTH bits,
//                                  out_sat is always 0
// -----------------------------------------------------------------------------
module mac_accumulator #(
  parameter int IN_WIDTH    = 32,
  parameter int ACC_WIDTH   = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_SCALE   = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  mac_accumulator_if.slave bus
);

  typedef enum logic {ST_ACCUM, ST_OUTPUT} state_t;

  state_t                      r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [COUNT_WIDTH-1:0]      r_cnt;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic [COUNT_WIDTH-1:0]      r_out_count;
  logic                        r_out_sat;
  logic                        r_out_valid;

  logic                        w_in_ready;
  logic                        w_take;
  logic signed [IN_WIDTH-1:0]  w_in_term;
  logic signed [ACC_WIDTH-1:0] w_term_sext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic [COUNT_WIDTH-1:0]      w_cnt_inc;
  logic signed [OUT_WIDTH-1:0] w_narrow;
  logic                        w_sat;

  // Ready is a pure decode of registered state; it never looks at in_valid.
  assign w_in_ready  = (r_state == ST_ACCUM) && !rst;
  assign w_take      = bus.in_valid && w_in_ready;

  assign w_in_term   = bus.in_data;
  assign w_term_sext = ACC_WIDTH'(w_in_term);
  assign w_sum       = r_acc + w_term_sext;   // wraps modulo 2^ACC_WIDTH
  assign w_shifted   = w_sum >>> OUT_SCALE;   // arithmetic: floor division

  // Term counter sticks at all-ones instead of wrapping to zero.
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef ACC_SATURATE_EN
  // Value fits in OUT_WIDTH iff every bit from the output sign bit upward
  // is a copy of the accumulator sign bit.
  logic [ACC_WIDTH-OUT_WIDTH:0] w_upper;
  logic                         w_fits;

  assign w_upper  = w_shifted[ACC_WIDTH-1:OUT_WIDTH-1];
  assign w_fits   = (&w_upper) || !(|w_upper);
  assign w_sat    = !w_fits;
  assign w_narrow = w_fits ? w_shifted[OUT_WIDTH-1:0] :
                    (w_shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(OUT_WIDTH-1){1'b1}}});
`else
  // Plain two's-complement truncation; the upper bits are intentionally dropped.
  logic w_unused_hi;

  assign w_unused_hi = ^w_shifted[ACC_WIDTH-1:OUT_WIDTH];
  assign w_narrow    = w_shifted[OUT_WIDTH-1:0];
  assign w_sat       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_take) begin
            if (bus.in_last) begin
              r_out_data  <= w_narrow;
              r_out_count <= w_cnt_inc;
              r_out_sat   <= w_sat;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= ST_OUTPUT;
            end else begin
              r_acc <= w_sum;
              r_cnt <= w_cnt_inc;
            end
          end
        end
        ST_OUTPUT: begin
          // Result registers stay frozen until the consumer takes them.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_valid = r_out_valid;

endmodule
